reg_file: RTL and testbench
===========================

# reg_file

Two-read/one-write 64-bit register file sitting directly upstream of the ALU. Its read ports drive the ALU operand inputs. Its write port takes the ALU result back at the clock edge, and it holds the architectural zero/overflow flag register loaded from the ALU flag outputs. After reset it clears its storage with a sequential sweep, so the array can map to block RAM without a wide reset.

## Interface
- DATA_W, 64, register width; matches ALU operand/result width
- NUM_REGS, 32, number of architectural registers
- ADDR_W, 5, register address width; equals clog2(NUM_REGS)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rs1_addr  in  ADDR_W  read port 1 address
- rs2_addr  in  ADDR_W  read port 2 address
- a_out  out  DATA_W  read port 1 data, drives ALU a_in
- b_out  out  DATA_W  read port 2 data, drives ALU b_in
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data, from ALU result
- flag_en  in  1  load flag register this cycle
- z_in  in  1  ALU zero flag
- o_in  in  1  ALU overflow flag
- z_flag  out  1  registered zero flag
- o_flag  out  1  registered overflow flag
- ready  out  1  high when sweep complete and file usable

## Operation
- FSM states are CLEAR and RUN. ready = (state == RUN).
- While rst is high:
  - state goes to CLEAR, clr_idx goes to 0.
  - z_flag and o_flag go to 0.
  - The array is not touched directly.
- CLEAR, each cycle with rst low:
  - Write 0 to mem[clr_idx] and increment clr_idx.
  - In the cycle that clears index NUM_REGS-1, go to RUN.
  - wr_en and flag_en are ignored.
  - a_out and b_out are forced to 0.
- RUN writes:
  - If wr_en and wr_addr != 0, then mem[wr_addr] <= wr_data.
  - Writes to register 0 are discarded.
- RUN reads are combinational:
  - If the address is 0, output 0.
  - Else, if wr_en and wr_addr equals the read address, output wr_data (write-through bypass).
  - Else, output mem[addr].
  - Both ports resolve independently and may hit the same address.
- Flags: in RUN, if flag_en, then z_flag <= z_in and o_flag <= o_in. Otherwise the flags hold.
- A write and a flag load in the same cycle both take effect.
- Reset mid-sweep or mid-RUN restarts the sweep from index 0. Prior contents are overwritten to 0 as the sweep proceeds.
- NUM_REGS must be a power of two and clr_idx is ADDR_W bits. Wrap-around is therefore never reached, because the FSM leaves CLEAR at NUM_REGS-1.

## Timing
- Reset values: state=CLEAR, clr_idx=0, ready=0, z_flag=0, o_flag=0, a_out=b_out=0.
- rst deasserted before edge E0:
  - Edges E0..E31 clear indices 0..31.
  - ready is high after edge E31, i.e. 32 cycles after the last rst-high cycle.
- Read latency is 0 cycles (combinational from address and bypass).
- Write latency: visible in mem after the next edge, visible on a_out/b_out in the same cycle via bypass.
- Flag latency: z_flag/o_flag update on the edge where flag_en is sampled high.

## Structure
- Shared package holds the DATA_W/ADDR_W/NUM_REGS defaults, the FSM state encoding (CLEAR, RUN) and the REG_ZERO address constant.
- No sub-module for the array; it is a single inferred memory.
- One natural sub-module: flag_reg, a 2-bit loadable register with synchronous reset, reusable by the branch unit.

## Test plan
- Reset sweep:
  - Stimulus: rst high for 3 cycles, then low. Count cycles to ready.
  - Required: ready=0 for 31 cycles, 1 after the 32nd edge. All 32 registers read 0.
- Write/read:
  - Stimulus: in RUN, write 64'h0123_4567_89AB_CDEF to r5. Next cycle rs1=5, rs2=5.
  - Required: a_out = b_out = 64'h0123_4567_89AB_CDEF.
- Bypass:
  - Stimulus: r7 holds 1. Same cycle: wr_en=1, wr_addr=7, wr_data=64'hFFFF_FFFF_FFFF_FFFF, rs1=7.
  - Required: a_out=all-ones that cycle and thereafter.
- Register zero:
  - Stimulus: write 64'hDEAD to r0 with rs2=0 the same and next cycle.
  - Required: b_out=0 both cycles.
- Reset mid-operation:
  - Stimulus: r3=64'h55 in RUN; assert rst for 1 cycle at sweep index 10, then again in RUN.
  - Required: sweep restarts, ready low 32 cycles, r3 reads 0. Writes issued during CLEAR are dropped.
- Flags:
  - Stimulus: flag_en=1, z_in=1, o_in=0; then flag_en=0, z_in=0, o_in=1.
  - Required: z_flag=1, o_flag=0 after the first edge, held after the second. Flags are 0 during CLEAR regardless of flag_en.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared parameters, FSM encoding and constants for the ALU-side register file.
// Also imported by anything that needs to agree on register width or the zero register.
package reg_file_pkg;

   localparam int DATA_W   = 64;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = $clog2(NUM_REGS);

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/reg_file_if.sv
// Read/write/flag bundle between the issue logic (master) and the register file (slave).
interface reg_file_if;
   import reg_file_pkg::*;

   logic [ADDR_W-1:0] rs1_addr;
   logic [ADDR_W-1:0] rs2_addr;
   logic [DATA_W-1:0] a_out;
   logic [DATA_W-1:0] b_out;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              flag_en;
   logic              z_in;
   logic              o_in;
   logic              z_flag;
   logic              o_flag;
   logic              ready;

   modport master (
      output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, flag_en, z_in, o_in,
      input  a_out, b_out, z_flag, o_flag, ready
   );

   modport slave (
      input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, flag_en, z_in, o_in,
      output a_out, b_out, z_flag, o_flag, ready
   );

endinterface

// File: rtl/reg_file_flag_reg.sv
// Two-bit loadable flag register with synchronous reset; shared with the branch unit.
module flag_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [1:0] d,
   output logic [1:0] q
);

   logic [1:0] flags_reg;

   always_ff @(posedge clk) begin
      if (rst)
         flags_reg <= 2'b00;
      else if (load)
         flags_reg <= d;
   end

   assign q = flags_reg;

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with write-through bypass and ALU flag register.
// Storage is cleared by a post-reset sweep so the array needs no wide reset.
module reg_file
   import reg_file_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   reg_file_if.slave  bus
);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;

   logic [DATA_W-1:0] mem [NUM_REGS];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic              run;
   logic [1:0]        flags_q;

   assign run = (state_reg == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= CLEAR;
         clr_idx_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_idx_reg <= clr_idx_next;
      end
   end

   // The sweep and the architectural write share the single memory write port.
   always_comb begin
      state_next   = state_reg;
      clr_idx_next = clr_idx_reg;
      mem_we       = 1'b0;
      mem_waddr    = bus.wr_addr;
      mem_wdata    = bus.wr_data;
      case (state_reg)
         CLEAR: begin
            mem_we       = 1'b1;
            mem_waddr    = clr_idx_reg;
            mem_wdata    = '0;
            clr_idx_next = clr_idx_reg + ADDR_W'(1);
            if (clr_idx_reg == ADDR_W'(NUM_REGS - 1))
               state_next = RUN;
         end
         RUN: begin
            mem_we = bus.wr_en && (bus.wr_addr != REG_ZERO);
         end
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we && !rst)
         mem[mem_waddr] <= mem_wdata;
   end

   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];

   assign rd_addr[0] = bus.rs1_addr;
   assign rd_addr[1] = bus.rs2_addr;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic [DATA_W-1:0] rd_val;
         always_comb begin
            rd_val = '0;
            if (run && rd_addr[gi] != REG_ZERO) begin
               if (bus.wr_en && bus.wr_addr == rd_addr[gi])
                  rd_val = bus.wr_data;
               else
                  rd_val = mem[rd_addr[gi]];
            end
         end
         assign rd_data[gi] = rd_val;
      end
   endgenerate

   assign bus.a_out = rd_data[0];
   assign bus.b_out = rd_data[1];
   assign bus.ready = run;

   flag_reg u_flag_reg (
      .clk  (clk),
      .rst  (rst),
      .load (run && bus.flag_en),
      .d    ({bus.z_in, bus.o_in}),
      .q    (flags_q)
   );

   assign bus.z_flag = flags_q[1];
   assign bus.o_flag = flags_q[0];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: the driver predicts each cycle's outputs from a
// behavioural model and queues them; a negedge monitor pops and compares.
module tb_reg_file;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   reg_file_if bus ();

   reg_file dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        rdy;
      logic [63:0] a;
      logic [63:0] b;
      logic        z;
      logic        o;
   } exp_t;

   exp_t exp_q[$];

   int pass_cnt  = 0;
   int total_cnt = 0;
   int txn_cnt   = 0;

   // Reference model: register contents, cycles of sweep still to go, flags.
   logic [63:0] mdl_mem [32];
   int          sweep_left = 32;
   logic        mdl_z = 1'b0;
   logic        mdl_o = 1'b0;
   bit          known = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total_cnt++;
      if (act !== expv)
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      else
         pass_cnt++;
   endtask

   function automatic logic [63:0] pred_rd(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [63:0] wd);
      if (sweep_left != 0 || a == 5'd0) return 64'd0;
      if (we && wa == a) return wd;
      return mdl_mem[a];
   endfunction

   task automatic cyc(input bit r, input bit we, input logic [4:0] wa, input logic [63:0] wd,
                      input bit fe, input bit z, input bit o,
                      input logic [4:0] a1, input logic [4:0] a2);
      exp_t e;
      @(posedge clk);
      #2;
      rst          = r;
      bus.wr_en    = we;
      bus.wr_addr  = wa;
      bus.wr_data  = wd;
      bus.flag_en  = fe;
      bus.z_in     = z;
      bus.o_in     = o;
      bus.rs1_addr = a1;
      bus.rs2_addr = a2;
      if (known) begin
         e.rdy = (sweep_left == 0);
         e.a   = pred_rd(a1, we, wa, wd);
         e.b   = pred_rd(a2, we, wa, wd);
         e.z   = mdl_z;
         e.o   = mdl_o;
         exp_q.push_back(e);
      end
      if (r) begin
         sweep_left = 32;
         mdl_z = 1'b0;
         mdl_o = 1'b0;
         for (int i = 0; i < 32; i++) mdl_mem[i] = 64'd0;
      end else if (sweep_left > 0) begin
         sweep_left--;
      end else begin
         if (we && wa != 5'd0) mdl_mem[wa] = wd;
         if (fe) begin
            mdl_z = z;
            mdl_o = o;
         end
      end
      known = 1'b1;
   endtask

   task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
      cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, a1, a2);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         txn_cnt++;
         $display("txn %0d rdy=%b a=%h b=%h z=%b o=%b", txn_cnt,
                  bus.ready, bus.a_out, bus.b_out, bus.z_flag, bus.o_flag);
         chk("ready", 64'(bus.ready), 64'(e.rdy));
         chk("a_out", bus.a_out, e.a);
         chk("b_out", bus.b_out, e.b);
         chk("z_flag", 64'(bus.z_flag), 64'(e.z));
         chk("o_flag", 64'(bus.o_flag), 64'(e.o));
      end
   end

   initial begin
      int  edges;
      bit  r, we, fe;
      logic [4:0]  wa, a1, a2;
      logic [63:0] wd;

      rst          = 1'b1;
      bus.wr_en    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.flag_en  = 1'b0;
      bus.z_in     = 1'b0;
      bus.o_in     = 1'b0;
      bus.rs1_addr = '0;
      bus.rs2_addr = '0;

      // Reset sweep: three reset cycles, then count edges until ready.
      repeat (3) cyc(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2);
      edges = -1;
      for (int k = 1; k <= 100; k++) begin
         cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 1'b1, 5'(k), 5'(k + 1));
         if (bus.ready) begin
            edges = k - 1;
            break;
         end
      end
      chk("sweep_edges", 64'(edges), 64'd32);
      for (int i = 0; i < 16; i++) idle(5'(2 * i), 5'(2 * i + 1));

      // Write then read on both ports.
      cyc(1'b0, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      idle(5'd5, 5'd5);

      // Bypass.
      cyc(1'b0, 1'b1, 5'd7, 64'd1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      cyc(1'b0, 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd7, 5'd5);
      idle(5'd7, 5'd7);

      // Register zero.
      cyc(1'b0, 1'b1, 5'd0, 64'hDEAD, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0);
      idle(5'd0, 5'd0);

      // Flags.
      cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
      cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
      idle(5'd0, 5'd0);

      // Reset mid-RUN, again at sweep index 10; writes and flag loads during CLEAR.
      cyc(1'b0, 1'b1, 5'd3, 64'h55, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3);
      idle(5'd3, 5'd5);
      cyc(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd3);
      for (int i = 0; i < 10; i++)
         cyc(1'b0, 1'b1, 5'd3, 64'h77, 1'b1, 1'b1, 1'b1, 5'd3, 5'd5);
      cyc(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd3);
      for (int i = 0; i < 33; i++)
         cyc(1'b0, 1'b1, 5'(i), {$urandom, $urandom}, 1'b1, 1'b1, 1'b1, 5'd3, 5'(i));
      for (int i = 0; i < 16; i++) idle(5'(2 * i), 5'(2 * i + 1));

      // Randomised traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         r  = ($urandom_range(0, 149) == 0);
         we = !r && $urandom_range(0, 1) == 1;
         fe = $urandom_range(0, 3) == 0;
         wa = 5'($urandom_range(0, 31));
         wd = {$urandom, $urandom};
         a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         cyc(r, we, wa, wd, fe, 1'($urandom), 1'($urandom), a1, a2);
      end

      @(posedge clk);
      #2;
      rst = 1'b0;
      bus.wr_en = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("queue_drain", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
